// File: rtl/imm_gen_pipe.sv
// Immediate/constant generator with a registered valid/ready output stage and a
// one-entry skid buffer; all state advances on the falling clock edge.
module imm_gen_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM0_W = 16,
  parameter int IMM1_W = 22,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [IMM1_W-1:0] imm_raw,
  input  logic [DATA_W-1:0] pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] const_out,
  output logic              out_ovf,
  output logic [15:0]       op_count
);

  localparam logic [1:0] MODE_SEXT0 = 2'd0;
  localparam logic [1:0] MODE_SEXT1 = 2'd1;
  localparam logic [1:0] MODE_ZEXT0 = 2'd2;
  localparam logic [1:0] MODE_PCREL = 2'd3;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  logic [DATA_W-1:0] sext0_s;
  logic [DATA_W-1:0] sext1_s;
  logic [DATA_W-1:0] zext0_s;
  logic [DATA_W-1:0] offs_s;
  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] res_s;
  logic              pc_ovf_s;
  logic              res_ovf_s;

  logic              accept_s;
  logic              xfer_s;
  logic              load_out_s;

  logic [DATA_W-1:0] out_data_r;
  logic [DATA_W-1:0] skid_data_r;
  logic              out_ovf_r;
  logic              skid_ovf_r;
  logic              out_valid_r;
  logic              skid_full_r;
  logic              in_ready_r;
  logic [15:0]       op_count_r;

  logic [DATA_W-1:0] out_data_nxt_s;
  logic [DATA_W-1:0] skid_data_nxt_s;
  logic              out_ovf_nxt_s;
  logic              skid_ovf_nxt_s;
  logic              out_valid_nxt_s;
  logic              skid_full_nxt_s;

  // Constant formation for all modes and the mode select.
  always_comb begin
    sext0_s  = {{(DATA_W-IMM0_W){imm_raw[IMM0_W-1]}}, imm_raw[IMM0_W-1:0]};
    sext1_s  = {{(DATA_W-IMM1_W){imm_raw[IMM1_W-1]}}, imm_raw};
    zext0_s  = {{(DATA_W-IMM0_W){1'b0}}, imm_raw[IMM0_W-1:0]};
    offs_s   = sext1_s << SHIFT;
    sum_s    = offs_s + pc_in;
    // Overflow only when both addends agree in sign and the sum does not.
    pc_ovf_s = (offs_s[DATA_W-1] == pc_in[DATA_W-1]) &&
               (sum_s[DATA_W-1] != pc_in[DATA_W-1]);
    res_s     = {DATA_W{1'b0}};
    res_ovf_s = 1'b0;
    case (mode)
      MODE_SEXT0: begin
        res_s     = sext0_s;
        res_ovf_s = 1'b0;
      end
      MODE_SEXT1: begin
        res_s     = sext1_s;
        res_ovf_s = 1'b0;
      end
      MODE_ZEXT0: begin
        res_s     = zext0_s;
        res_ovf_s = 1'b0;
      end
      MODE_PCREL: begin
        res_s     = sum_s;
        res_ovf_s = pc_ovf_s;
      end
      default: begin
        res_s     = {DATA_W{1'b0}};
        res_ovf_s = 1'b0;
      end
    endcase
  end

  // Handshake qualifiers.
  always_comb begin
    accept_s   = in_valid & in_ready_r;
    xfer_s     = out_valid_r & out_ready;
    load_out_s = ~out_valid_r | xfer_s;
  end

  // Next state of output stage and skid; skid contents always leave first.
  always_comb begin
    out_data_nxt_s  = out_data_r;
    out_ovf_nxt_s   = out_ovf_r;
    out_valid_nxt_s = out_valid_r;
    skid_data_nxt_s = skid_data_r;
    skid_ovf_nxt_s  = skid_ovf_r;
    skid_full_nxt_s = skid_full_r;
    if (load_out_s) begin
      if (skid_full_r) begin
        out_data_nxt_s  = skid_data_r;
        out_ovf_nxt_s   = skid_ovf_r;
        out_valid_nxt_s = 1'b1;
        if (accept_s) begin
          skid_data_nxt_s = res_s;
          skid_ovf_nxt_s  = res_ovf_s;
          skid_full_nxt_s = 1'b1;
        end else begin
          skid_full_nxt_s = 1'b0;
        end
      end else if (accept_s) begin
        out_data_nxt_s  = res_s;
        out_ovf_nxt_s   = res_ovf_s;
        out_valid_nxt_s = 1'b1;
      end else begin
        out_valid_nxt_s = 1'b0;
      end
    end else if (accept_s) begin
      skid_data_nxt_s = res_s;
      skid_ovf_nxt_s  = res_ovf_s;
      skid_full_nxt_s = 1'b1;
    end else begin
      skid_full_nxt_s = skid_full_r;
    end
  end

  // Pipeline registers; in_ready is registered from the next skid state.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {DATA_W{1'b0}};
      out_ovf_r   <= 1'b0;
      out_valid_r <= 1'b0;
      skid_data_r <= {DATA_W{1'b0}};
      skid_ovf_r  <= 1'b0;
      skid_full_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      out_data_r  <= out_data_nxt_s;
      out_ovf_r   <= out_ovf_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      skid_ovf_r  <= skid_ovf_nxt_s;
      skid_full_r <= skid_full_nxt_s;
      in_ready_r  <= ~skid_full_nxt_s;
    end
  end

  // Saturating count of accepted operations.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= 16'd0;
    end else if (accept_s && (op_count_r != CNT_MAX)) begin
      op_count_r <= op_count_r + 16'd1;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign const_out = out_data_r;
  assign out_ovf   = out_ovf_r;
  assign op_count  = op_count_r;

endmodule
